// File: rtl/pm_motor_arb.sv
// pm_motor_arb: shares one stepper-motor driver between two position-mode
// controllers. Start requests are latched per channel, one channel owns the
// driver for a whole move (start through stop), and only its commands reach
// the driver.
//
// Ports:
//   clk, reset                   clock, synchronous active-high reset
//   sN_start/stop/mod_remain     channel command pulses (N = 0, 1)
//   sN_speed/step/dir            move parameters, captured with sN_start
//   sN_new_remain                remain value sent with sN_mod_remain
//   sN_state                     m_state while channel N owns the driver
//   sN_position                  driver position, shown to both channels
//   sN_done                      one-cycle pulse when channel N's move ends
//   m_state, m_position          driver status
//   m_start/stop/mod_remain      driver command pulses
//   m_speed/step/dir/new_remain  driver command values
//   m_sel                        driver enable, low while in reset
//   owner                        one-hot owner, 00 when idle
//   err_timeout                  sticky: driver never started running
module pm_motor_arb #(
  parameter int unsigned C_STEP_NUMBER_WIDTH = 32,
  parameter int unsigned C_SPEED_DATA_WIDTH  = 32,
  parameter int unsigned C_RUN_TIMEOUT       = 1024
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           s0_start,
  input  logic                           s0_stop,
  input  logic [C_SPEED_DATA_WIDTH-1:0]  s0_speed,
  input  logic [C_STEP_NUMBER_WIDTH-1:0] s0_step,
  input  logic                           s0_dir,
  input  logic                           s0_mod_remain,
  input  logic [C_STEP_NUMBER_WIDTH-1:0] s0_new_remain,
  output logic                           s0_state,
  output logic [C_STEP_NUMBER_WIDTH-1:0] s0_position,
  output logic                           s0_done,
  input  logic                           s1_start,
  input  logic                           s1_stop,
  input  logic [C_SPEED_DATA_WIDTH-1:0]  s1_speed,
  input  logic [C_STEP_NUMBER_WIDTH-1:0] s1_step,
  input  logic                           s1_dir,
  input  logic                           s1_mod_remain,
  input  logic [C_STEP_NUMBER_WIDTH-1:0] s1_new_remain,
  output logic                           s1_state,
  output logic [C_STEP_NUMBER_WIDTH-1:0] s1_position,
  output logic                           s1_done,
  input  logic                           m_state,
  input  logic [C_STEP_NUMBER_WIDTH-1:0] m_position,
  output logic                           m_start,
  output logic                           m_stop,
  output logic                           m_mod_remain,
  output logic [C_SPEED_DATA_WIDTH-1:0]  m_speed,
  output logic [C_STEP_NUMBER_WIDTH-1:0] m_step,
  output logic [C_STEP_NUMBER_WIDTH-1:0] m_new_remain,
  output logic                           m_dir,
  output logic                           m_sel,
  output logic [1:0]                     owner,
  output logic                           err_timeout
);

  localparam int unsigned SW    = C_SPEED_DATA_WIDTH;
  localparam int unsigned NW    = C_STEP_NUMBER_WIDTH;
  localparam int unsigned CNT_W = $clog2(C_RUN_TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ISSUE, S_WAIT_RUN, S_RUN, S_RELEASE
  } state_t;

  state_t state, state_nxt;

  // Per-channel views of the request ports
  logic [1:0]    start_v, stop_v;
  logic [SW-1:0] speed_in  [2];
  logic [NW-1:0] step_in   [2];
  logic [1:0]    dir_in;

  assign start_v     = {s1_start, s0_start};
  assign stop_v      = {s1_stop, s0_stop};
  assign speed_in[0] = s0_speed;
  assign speed_in[1] = s1_speed;
  assign step_in[0]  = s0_step;
  assign step_in[1]  = s1_step;
  assign dir_in      = {s1_dir, s0_dir};

  // Pending flags and captured move parameters
  logic [1:0]    pend;
  logic [SW-1:0] hold_speed [2];
  logic [NW-1:0] hold_step  [2];
  logic [1:0]    hold_dir;
  logic          last_owner;
  logic [CNT_W-1:0] cnt;

  logic [1:0]    grant_c;
  logic          issue_c, fwd_c, release_c, timeout_c;
  logic          own_stop_c, own_mod_c;
  logic [NW-1:0] own_remain_c;

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:     if (pend != 2'b00) state_nxt = S_ISSUE;
      S_ISSUE:    state_nxt = S_WAIT_RUN;
      S_WAIT_RUN: begin
        if (m_state)        state_nxt = S_RUN;
        else if (timeout_c) state_nxt = S_RELEASE;
      end
      S_RUN:      if (!m_state) state_nxt = S_RELEASE;
      S_RELEASE:  state_nxt = S_IDLE;
      default:    state_nxt = S_IDLE;
    endcase
  end

  // Per-state control decodes feeding the registered outputs
  always_comb begin
    grant_c      = 2'b00;
    issue_c      = 1'b0;
    fwd_c        = 1'b0;
    release_c    = 1'b0;
    timeout_c    = 1'b0;
    own_stop_c   = (owner[0] & s0_stop) | (owner[1] & s1_stop);
    own_mod_c    = (owner[0] & s0_mod_remain) | (owner[1] & s1_mod_remain);
    own_remain_c = owner[1] ? s1_new_remain : s0_new_remain;
    case (state)
      S_IDLE: begin
        // Tie goes to the channel that did not own the last move
        if (pend == 2'b11) grant_c = last_owner ? 2'b01 : 2'b10;
        else               grant_c = pend;
      end
      S_ISSUE:    issue_c = 1'b1;
      S_WAIT_RUN: begin
        fwd_c     = 1'b1;
        timeout_c = !m_state && (cnt == CNT_W'(C_RUN_TIMEOUT - 1));
      end
      S_RUN:      fwd_c = 1'b1;
      S_RELEASE:  release_c = 1'b1;
      default:    ;
    endcase
  end

  // Request latch; a channel being granted this cycle counts as owner
  always_ff @(posedge clk) begin
    if (reset) begin
      pend     <= 2'b00;
      hold_dir <= 2'b00;
      for (int n = 0; n < 2; n++) begin
        hold_speed[n] <= '0;
        hold_step[n]  <= '0;
      end
    end else begin
      for (int n = 0; n < 2; n++) begin
        if (start_v[n] && !owner[n] && !grant_c[n]) begin
          pend[n]       <= 1'b1;
          hold_speed[n] <= speed_in[n];
          hold_step[n]  <= step_in[n];
          hold_dir[n]   <= dir_in[n];
        end else if (grant_c[n]) begin
          pend[n] <= 1'b0;
        end else if (stop_v[n] && pend[n] && !owner[n]) begin
          pend[n] <= 1'b0;
        end
      end
    end
  end

  // Ownership, timeout counter and all registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      owner        <= 2'b00;
      last_owner   <= 1'b1;
      cnt          <= '0;
      m_start      <= 1'b0;
      m_stop       <= 1'b0;
      m_mod_remain <= 1'b0;
      m_speed      <= '0;
      m_step       <= '0;
      m_new_remain <= '0;
      m_dir        <= 1'b0;
      m_sel        <= 1'b0;
      s0_done      <= 1'b0;
      s1_done      <= 1'b0;
      s0_state     <= 1'b0;
      s1_state     <= 1'b0;
      s0_position  <= '0;
      s1_position  <= '0;
      err_timeout  <= 1'b0;
    end else begin
      if (grant_c != 2'b00) owner <= grant_c;
      else if (release_c)   owner <= 2'b00;
      if (release_c) last_owner <= owner[1];

      if (issue_c)                  cnt <= '0;
      else if (state == S_WAIT_RUN) cnt <= cnt + 1'b1;

      m_start <= issue_c;
      if (issue_c) begin
        m_speed <= hold_speed[owner[1]];
        m_step  <= hold_step[owner[1]];
        m_dir   <= hold_dir[owner[1]];
      end

      m_stop       <= fwd_c & own_stop_c;
      m_mod_remain <= fwd_c & own_mod_c;
      if (fwd_c && own_mod_c) m_new_remain <= own_remain_c;

      m_sel       <= 1'b1;
      s0_done     <= release_c & owner[0];
      s1_done     <= release_c & owner[1];
      s0_state    <= m_state & owner[0];
      s1_state    <= m_state & owner[1];
      s0_position <= m_position;
      s1_position <= m_position;
      if (timeout_c) err_timeout <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pm_motor_arb.sv
module tb_pm_motor_arb;

  localparam int unsigned NW = 32;
  localparam int unsigned SW = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          s0_start, s0_stop, s0_dir, s0_mod_remain;
  logic [SW-1:0] s0_speed;
  logic [NW-1:0] s0_step, s0_new_remain;
  logic          s0_state, s0_done;
  logic [NW-1:0] s0_position;
  logic          s1_start, s1_stop, s1_dir, s1_mod_remain;
  logic [SW-1:0] s1_speed;
  logic [NW-1:0] s1_step, s1_new_remain;
  logic          s1_state, s1_done;
  logic [NW-1:0] s1_position;
  logic          m_state;
  logic [NW-1:0] m_position;
  logic          m_start, m_stop, m_mod_remain, m_dir, m_sel;
  logic [SW-1:0] m_speed;
  logic [NW-1:0] m_step, m_new_remain;
  logic [1:0]    owner;
  logic          err_timeout;

  int n_cmp = 0;
  int n_err = 0;

  pm_motor_arb #(
    .C_STEP_NUMBER_WIDTH(NW),
    .C_SPEED_DATA_WIDTH (SW),
    .C_RUN_TIMEOUT      (8)
  ) dut (
    .clk(clk), .reset(reset),
    .s0_start(s0_start), .s0_stop(s0_stop), .s0_speed(s0_speed),
    .s0_step(s0_step), .s0_dir(s0_dir), .s0_mod_remain(s0_mod_remain),
    .s0_new_remain(s0_new_remain), .s0_state(s0_state),
    .s0_position(s0_position), .s0_done(s0_done),
    .s1_start(s1_start), .s1_stop(s1_stop), .s1_speed(s1_speed),
    .s1_step(s1_step), .s1_dir(s1_dir), .s1_mod_remain(s1_mod_remain),
    .s1_new_remain(s1_new_remain), .s1_state(s1_state),
    .s1_position(s1_position), .s1_done(s1_done),
    .m_state(m_state), .m_position(m_position),
    .m_start(m_start), .m_stop(m_stop), .m_mod_remain(m_mod_remain),
    .m_speed(m_speed), .m_step(m_step), .m_new_remain(m_new_remain),
    .m_dir(m_dir), .m_sel(m_sel), .owner(owner), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  // Advance one clock; outputs are then read 1 time unit after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1;
    {s0_start, s0_stop, s0_dir, s0_mod_remain} = '0;
    {s1_start, s1_stop, s1_dir, s1_mod_remain} = '0;
    s0_speed = '0; s0_step = '0; s0_new_remain = '0;
    s1_speed = '0; s1_step = '0; s1_new_remain = '0;
    m_state = 1'b0; m_position = 32'd1234;

    // Reset state
    tick(); tick(); tick();
    chk("rst_owner", 64'(owner), 64'd0);
    chk("rst_m_sel", 64'(m_sel), 64'd0);
    chk("rst_m_start", 64'(m_start), 64'd0);
    chk("rst_err", 64'(err_timeout), 64'd0);
    chk("rst_pos", 64'(s0_position), 64'd0);
    reset = 1'b0;
    tick();
    chk("m_sel_on", 64'(m_sel), 64'd1);
    chk("pos0_pass", 64'(s0_position), 64'd1234);
    chk("pos1_pass", 64'(s1_position), 64'd1234);

    // Single move on channel 0: two-cycle start latency
    s0_start = 1'b1; s0_speed = 32'd100; s0_step = 32'd500; s0_dir = 1'b1;
    tick();
    s0_start = 1'b0; s0_speed = '0; s0_step = '0; s0_dir = 1'b0;
    chk("t1_start_lat1", 64'(m_start), 64'd0);
    tick();
    chk("t1_owner", 64'(owner), 64'd1);
    chk("t1_start_lat2", 64'(m_start), 64'd0);
    tick();
    chk("t1_m_start", 64'(m_start), 64'd1);
    chk("t1_m_speed", 64'(m_speed), 64'd100);
    chk("t1_m_step", 64'(m_step), 64'd500);
    chk("t1_m_dir", 64'(m_dir), 64'd1);
    tick();
    chk("t1_m_start_pulse", 64'(m_start), 64'd0);
    chk("t1_speed_held", 64'(m_speed), 64'd100);
    m_state = 1'b1;
    tick();
    chk("t1_s0_state", 64'(s0_state), 64'd1);
    chk("t1_s1_state", 64'(s1_state), 64'd0);

    // Non-owner stop/mod_remain are blocked
    s1_stop = 1'b1; s1_mod_remain = 1'b1; s1_new_remain = 32'd5;
    tick();
    s1_stop = 1'b0; s1_mod_remain = 1'b0;
    chk("t3_block_stop", 64'(m_stop), 64'd0);
    chk("t3_block_mod", 64'(m_mod_remain), 64'd0);
    // Owner mod_remain forwarded with one-cycle latency
    s0_mod_remain = 1'b1; s0_new_remain = 32'd77;
    tick();
    s0_mod_remain = 1'b0;
    chk("t3_fwd_mod", 64'(m_mod_remain), 64'd1);
    chk("t3_fwd_remain", 64'(m_new_remain), 64'd77);
    tick();
    chk("t3_mod_pulse", 64'(m_mod_remain), 64'd0);
    s0_stop = 1'b1;
    tick();
    s0_stop = 1'b0;
    chk("t3_fwd_stop", 64'(m_stop), 64'd1);
    tick();
    chk("t3_stop_pulse", 64'(m_stop), 64'd0);

    // Queued channel 1 request withdrawn before it is served
    s1_start = 1'b1; s1_speed = 32'd7; s1_step = 32'd9;
    tick();
    s1_start = 1'b0;
    s1_stop = 1'b1;
    tick();
    s1_stop = 1'b0;

    // End of channel 0 move
    m_state = 1'b0;
    tick();
    chk("t1_owner_hold", 64'(owner), 64'd1);
    tick();
    chk("t1_s0_done", 64'(s0_done), 64'd1);
    chk("t1_s1_done", 64'(s1_done), 64'd0);
    chk("t1_owner_free", 64'(owner), 64'd0);
    tick();
    chk("t1_done_pulse", 64'(s0_done), 64'd0);
    for (int i = 0; i < 5; i++) begin
      chk("t4_no_start", 64'(m_start), 64'd0);
      chk("t4_idle_owner", 64'(owner), 64'd0);
      tick();
    end

    // Tie after reset: channel 0 first, then channel 1 automatically
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    s0_start = 1'b1; s0_speed = 32'd11; s0_step = 32'd22; s0_dir = 1'b0;
    s1_start = 1'b1; s1_speed = 32'd33; s1_step = 32'd44; s1_dir = 1'b1;
    tick();
    s0_start = 1'b0; s1_start = 1'b0;
    tick();
    chk("t2_tie_owner0", 64'(owner), 64'd1);
    tick();
    chk("t2_c0_start", 64'(m_start), 64'd1);
    chk("t2_c0_speed", 64'(m_speed), 64'd11);
    chk("t2_c0_step", 64'(m_step), 64'd22);
    chk("t2_c0_dir", 64'(m_dir), 64'd0);
    m_state = 1'b1;
    tick();
    m_state = 1'b0;
    tick();
    tick();
    chk("t2_c0_done", 64'(s0_done), 64'd1);
    tick();
    chk("t2_owner1", 64'(owner), 64'd2);
    tick();
    chk("t2_c1_start", 64'(m_start), 64'd1);
    chk("t2_c1_speed", 64'(m_speed), 64'd33);
    chk("t2_c1_step", 64'(m_step), 64'd44);
    chk("t2_c1_dir", 64'(m_dir), 64'd1);
    m_state = 1'b1;
    tick();
    chk("t2_s1_state", 64'(s1_state), 64'd1);
    chk("t2_s0_state", 64'(s0_state), 64'd0);
    m_state = 1'b0;
    tick();
    tick();
    chk("t2_c1_done", 64'(s1_done), 64'd1);
    chk("t2_owner_free", 64'(owner), 64'd0);
    // Second tie: last owner was channel 1, so channel 0 wins
    s0_start = 1'b1; s1_start = 1'b1;
    tick();
    s0_start = 1'b0; s1_start = 1'b0;
    tick();
    chk("t2_tie2_owner0", 64'(owner), 64'd1);
    tick();
    m_state = 1'b1;
    tick();
    m_state = 1'b0;
    tick();
    tick();
    chk("t2_tie2_done0", 64'(s0_done), 64'd1);
    // Channel 1 still pending from the second tie
    tick();
    chk("t2_tie2_owner1", 64'(owner), 64'd2);
    tick();
    m_state = 1'b1;
    tick();
    m_state = 1'b0;
    tick();
    tick();
    chk("t2_tie2_done1", 64'(s1_done), 64'd1);
    tick();

    // Timeout: m_state never rises
    s0_start = 1'b1; s0_speed = 32'd3;
    tick();
    s0_start = 1'b0;
    tick();
    tick();
    chk("t5_m_start", 64'(m_start), 64'd1);
    for (int i = 0; i < 7; i++) tick();
    chk("t5_err_early", 64'(err_timeout), 64'd0);
    tick();
    chk("t5_err_set", 64'(err_timeout), 64'd1);
    tick();
    chk("t5_done", 64'(s0_done), 64'd1);
    chk("t5_owner_free", 64'(owner), 64'd0);
    tick();
    chk("t5_err_sticky", 64'(err_timeout), 64'd1);

    // Reset during RUN, then a start+stop on channel 1 still issues
    s0_start = 1'b1;
    tick();
    s0_start = 1'b0;
    tick();
    tick();
    m_state = 1'b1;
    tick();
    chk("t6_running", 64'(s0_state), 64'd1);
    reset = 1'b1; m_state = 1'b0;
    tick();
    chk("t6_owner", 64'(owner), 64'd0);
    chk("t6_m_sel", 64'(m_sel), 64'd0);
    chk("t6_s0_state", 64'(s0_state), 64'd0);
    chk("t6_err_clr", 64'(err_timeout), 64'd0);
    chk("t6_m_speed", 64'(m_speed), 64'd0);
    reset = 1'b0;
    tick();
    s1_start = 1'b1; s1_stop = 1'b1; s1_speed = 32'd5; s1_step = 32'd6; s1_dir = 1'b1;
    tick();
    s1_start = 1'b0; s1_stop = 1'b0;
    tick();
    chk("t6_owner1", 64'(owner), 64'd2);
    tick();
    chk("t6_m_start", 64'(m_start), 64'd1);
    chk("t6_m_speed1", 64'(m_speed), 64'd5);
    chk("t6_m_step1", 64'(m_step), 64'd6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
